// File: rtl/conv_operand_mem.sv
// Operand/result store for the systolic convolution datapath: image A, kernel B, result C,
// host byte port, result write-back and a windowed (A,B) stream sequencer. Option: CONV_PRELOAD_EN.
module conv_operand_mem #(
  parameter int N  = 4,
  parameter int K  = 3,
  parameter int DW = 8,
  parameter int AW = 5,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_err,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          res_en,
  input  logic [IW-1:0] res_row,
  input  logic [IW-1:0] res_col,
  input  logic [DW-1:0] res_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          s_valid,
  input  logic          s_ready,
  output logic [DW-1:0] s_a,
  output logic [DW-1:0] s_b,
  output logic          s_first,
  output logic          s_last,
  output logic [IW-1:0] s_row,
  output logic [IW-1:0] s_col
);
  localparam int M     = N - K + 1;
  localparam int NN    = N * N;
  localparam int KK    = K * K;
  localparam int DEPTH = NN + KK + M * M;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] AB_END  = (AW+1)'(NN + KK);
  localparam logic [IW:0] M_W     = (IW+1)'(M);

  generate
    if ((1 << AW) < DEPTH) begin : g_aw_chk
      $error("AW too small for DEPTH");
    end
    if ((1 << IW) < M) begin : g_iw_chk
      $error("IW too small for M");
    end
  endgenerate

`ifdef CONV_PRELOAD_EN
  generate
    if (N != 4 || K != 3) begin : g_preload_chk
      $error("CONV_PRELOAD_EN demo operands need N=4, K=3");
    end
  endgenerate
  localparam int PRE [25] = '{4,6,5,1, 1,2,3,4, 7,8,9,3, 5,7,2,7,
                              2,3,2, 4,6,5, 1,7,1};
  function automatic logic [DW-1:0] init_val(input int k);
    return (k < 25) ? DW'(PRE[k]) : '0;
  endfunction
`else
  function automatic logic [DW-1:0] init_val(input int k);
    return (k < 0) ? '1 : '0;
  endfunction
`endif

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  logic [DW-1:0] mem [DEPTH];
  state_t        state;
  logic [IW-1:0] r, c;
  logic [KW-1:0] i, j;
  logic [AW-1:0] a_addr, b_addr, res_addr;
  logic          wr_ok, res_ok, accept;

  // A and B are frozen while the sequencer owns them; C stays writable.
  always_comb begin
    wr_ok  = wr_en && ({1'b0, wr_addr} < DEPTH_W) &&
             !(busy && ({1'b0, wr_addr} < AB_END));
    res_ok = res_en && ({1'b0, res_row} < M_W) && ({1'b0, res_col} < M_W);
    res_addr = AW'(NN + KK + int'(res_row) * M + int'(res_col));
    a_addr   = AW'((int'(r) + int'(i)) * N + int'(c) + int'(j));
    b_addr   = AW'(NN + int'(i) * K + int'(j));
    accept   = s_valid && s_ready;
  end

  assign s_a     = mem[a_addr];
  assign s_b     = mem[b_addr];
  assign s_first = (i == '0) && (j == '0);
  assign s_last  = (i == KW'(K-1)) && (j == KW'(K-1));
  assign s_row   = r;
  assign s_col   = c;

  // Result write-back is applied after the host write so it wins on collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= init_val(k);
      rd_data <= '0;
      wr_err  <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_ok;
      if (wr_ok)  mem[wr_addr]  <= wr_data;
      if (res_ok) mem[res_addr] <= res_data;
      rd_data <= ({1'b0, rd_addr} < DEPTH_W) ? mem[rd_addr] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      s_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      r <= '0; c <= '0; i <= '0; j <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= S_STREAM;
            s_valid <= 1'b1;
            busy    <= 1'b1;
            r <= '0; c <= '0; i <= '0; j <= '0;
          end
        end
        S_STREAM: begin
          if (accept) begin
            // j is the fastest index, r the slowest
            if (j == KW'(K-1)) begin
              j <= '0;
              if (i == KW'(K-1)) begin
                i <= '0;
                if (c == IW'(M-1)) begin
                  c <= '0;
                  if (r == IW'(M-1)) begin
                    r       <= '0;
                    state   <= S_DONE;
                    s_valid <= 1'b0;
                    done    <= 1'b1;
                  end else begin
                    r <= r + 1'b1;
                  end
                end else begin
                  c <= c + 1'b1;
                end
              end else begin
                i <= i + 1'b1;
              end
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          s_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end
endmodule
